// File: rtl/rr_arbiter_enc.sv
// Four-requester round-robin arbiter with a registered 2-bit grant index.
// An owner keeps the grant while it requests, up to MAX_HOLD cycles; priority then rotates past it.
module rr_arbiter_enc #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [1:0]       grant_idx,
  output logic             grant_valid,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [1:0]       idx_n;
  logic             valid_n;
  logic [CNT_W-1:0] cnt_n;

  logic [2:0]       pick_cur;
  logic [2:0]       pick_rot;
  logic [1:0]       ptr_rot;
  logic             release_g;

  // Returns {found, index} of the first set bit scanning from p upward, modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] j;
    logic [2:0] res;
    res = 3'b000;
    for (int off = 3; off >= 0; off--) begin
      j = p + 2'(off);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  assign ptr_rot   = grant_idx + 2'd1;
  assign pick_cur  = rr_pick(req, ptr);
  assign pick_rot  = rr_pick(req, ptr_rot);
  assign release_g = !req[grant_idx] || (hold_cnt == CNT_W'(MAX_HOLD));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n = state;
    ptr_n   = ptr;
    idx_n   = grant_idx;
    valid_n = grant_valid;
    cnt_n   = hold_cnt;
    unique case (state)
      IDLE: begin
        if (pick_cur[2]) begin
          state_n = GRANT;
          idx_n   = pick_cur[1:0];
          valid_n = 1'b1;
          cnt_n   = CNT_W'(1);
        end else begin
          valid_n = 1'b0;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (!release_g) begin
          cnt_n = hold_cnt + CNT_W'(1);
        end else begin
          // The old owner becomes lowest priority and the handoff happens in the same edge.
          ptr_n = ptr_rot;
          if (pick_rot[2]) begin
            idx_n = pick_rot[1:0];
            cnt_n = CNT_W'(1);
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            cnt_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant_idx   <= idx_n;
      grant_valid <= valid_n;
      hold_cnt    <= cnt_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_enc.sv
// Drives two arbiters (MAX_HOLD=3 and MAX_HOLD=1) from shared requests and
// compares both against a per-instance behavioural round-robin model.
module tb_rr_arbiter_enc;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [1:0]       a_idx, b_idx;
  logic             a_valid, b_valid;
  logic [CNT_W-1:0] a_cnt, b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int m_max   [2] = '{3, 1};
  int m_valid [2];
  int m_idx   [2];
  int m_cnt   [2];
  int m_ptr   [2];

  always #5 clk = ~clk;

  rr_arbiter_enc #(.MAX_HOLD(3), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant_idx(a_idx), .grant_valid(a_valid), .hold_cnt(a_cnt)
  );

  rr_arbiter_enc #(.MAX_HOLD(1), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant_idx(b_idx), .grant_valid(b_valid), .hold_cnt(b_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scan(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++) begin
      if (r[(p + off) % 4]) return (p + off) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_idx[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r);
    int w;
    for (int k = 0; k < 2; k++) begin
      if (m_valid[k] == 0) begin
        w = scan(r, m_ptr[k]);
        if (w >= 0) begin
          m_valid[k] = 1; m_idx[k] = w; m_cnt[k] = 1;
        end
      end else if (r[m_idx[k]] && m_cnt[k] < m_max[k]) begin
        m_cnt[k]++;
      end else begin
        m_ptr[k] = (m_idx[k] + 1) % 4;
        w = scan(r, m_ptr[k]);
        if (w >= 0) begin
          m_idx[k] = w; m_cnt[k] = 1;
        end else begin
          m_valid[k] = 0; m_cnt[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".a.valid"}, int'(a_valid), m_valid[0]);
    check({tag, ".a.idx"},   int'(a_idx),   m_idx[0]);
    check({tag, ".a.cnt"},   int'(a_cnt),   m_cnt[0]);
    check({tag, ".b.valid"}, int'(b_valid), m_valid[1]);
    check({tag, ".b.idx"},   int'(b_idx),   m_idx[1]);
    check({tag, ".b.cnt"},   int'(b_cnt),   m_cnt[1]);
  endtask

  // One clock: present req, let the edge happen, advance the model, check 1 ns later.
  task automatic cycle(input logic [3:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-grant with all requesting, then first grant goes to requester 0.
    cycle(4'b1111, "pre");
    cycle(4'b1111, "pre");
    req = 4'b1111;
    do_reset();
    check("rst.valid", int'(a_valid), 0);
    check("rst.idx",   int'(a_idx),   0);
    check("rst.cnt",   int'(a_cnt),   0);
    cycle(4'b1111, "first");
    check("first.idx", int'(a_idx), 0);

    // Single requester 2 for three cycles then drop.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      cycle(4'b0100, "single");
      check("single.idx", int'(a_idx), 2);
      check("single.cnt", int'(a_cnt), i);
    end
    cycle(4'b0000, "single_drop");
    check("single_drop.valid", int'(a_valid), 0);
    check("single_drop.cnt",   int'(a_cnt),   0);

    // Constant full requests: rotation 0,1,2,3,0 each held MAX_HOLD cycles.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(4'b1111, "rr");
      check("rr.idx", int'(a_idx), (i / 3) % 4);
      check("rr.cnt", int'(a_cnt), (i % 3) + 1);
      check("rr1.idx", int'(b_idx), i % 4);
    end

    // Early release from owner 1 hands straight to owner 0.
    do_reset();
    cycle(4'b0010, "early");
    cycle(4'b0011, "early");
    cycle(4'b0001, "early");
    check("early.idx",   int'(a_idx),   0);
    check("early.cnt",   int'(a_cnt),   1);
    check("early.valid", int'(a_valid), 1);

    // Sole requester 3 times out and is re-granted; then wrap to 0 and back to 3.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1000, "timeout");
      check("timeout.idx", int'(a_idx), 3);
      check("timeout.cnt", int'(a_cnt), (i % 3) + 1);
    end
    cycle(4'b1001, "wrap");
    check("wrap.idx", int'(a_idx), 0);
    cycle(4'b1001, "wrap");
    cycle(4'b1001, "wrap");
    cycle(4'b1001, "wrap");
    check("wrap.back", int'(a_idx), 3);

    // Randomized traffic with sticky requests to exercise long holds.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req;
      if ($urandom_range(0, 19) == 0) r = 4'b0000;
      cycle(r, "rand");
      if (i == 200) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
